shift_pipe: RTL

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pipe.sv | 118 +++++++++++
 1 files changed

// File: rtl/shift_pipe.sv
// shift_pipe: two-stage shift/rotate pipeline with valid/ready handshake.
//
// The shift amount is split across the two stages.
//   Stage 1 applies in_shamt with its low SPLIT bits cleared.
//   Stage 2 applies the residual low SPLIT bits.
// out_data comes straight from the stage-2 register.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand presented
//   in_ready   stage 1 can accept this cycle (combinational)
//   in_data    operand, WIDTH bits
//   in_shamt   shift amount, 0..WIDTH-1
//   in_op      00 SLL, 01 SRL, 10 SRA, 11 ROL
//   flush      synchronous kill of everything in flight
//   out_valid  result available
//   out_ready  consumer accepts the result this cycle
//   out_data   result
module shift_pipe #(
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [$clog2(WIDTH)-1:0] in_shamt,
   input  logic [1:0]               in_op,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data
);

   localparam int SHW   = $clog2(WIDTH);
   localparam int SPLIT = SHW / 2;

   function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] d,
                                                 input logic [1:0]       op,
                                                 input logic [SHW-1:0]   amt);
      logic [2*WIDTH-1:0] rot;
      rot = {d, d} << amt;
      case (op)
         2'b00:   shift_op = d << amt;
         2'b01:   shift_op = d >> amt;
         2'b10:   shift_op = $signed(d) >>> amt;
         default: shift_op = rot[2*WIDTH-1:WIDTH];
      endcase
   endfunction

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_data_q,  s1_data_d;
   logic [1:0]       s1_op_q,    s1_op_d;
   logic [SPLIT-1:0] s1_shamt_q, s1_shamt_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_data_q,  s2_data_d;

   logic             s1_adv;
   logic             s2_adv;
   logic [SHW-1:0]   s1_amt;
   logic [SHW-1:0]   s2_amt;

   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv && !flush;

   assign s1_amt = {in_shamt[SHW-1:SPLIT], {SPLIT{1'b0}}};
   assign s2_amt = {{(SHW-SPLIT){1'b0}}, s1_shamt_q};

   // Stage 2 consumes the whole residual shift.
   // Its op and shamt are therefore fully applied and are not carried further.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_op_d    = s1_op_q;
      s1_shamt_d = s1_shamt_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = shift_op(s1_data_q, s1_op_q, s2_amt);
         end
         if (s1_adv) begin
            s1_valid_d = in_valid;
            s1_data_d  = shift_op(in_data, in_op, s1_amt);
            s1_op_d    = in_op;
            s1_shamt_d = in_shamt[SPLIT-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_op_q    <= '0;
         s1_shamt_q <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_op_q    <= s1_op_d;
         s1_shamt_q <= s1_shamt_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;

endmodule
